param_sync_fifo: RTL and testbench

//   Single-clock FIFO with valid/ready handshakes on both sides, first-word-fall-through read.

---
 rtl/param_sync_fifo.sv | 101 ++++++++++
 tb/tb_param_sync_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO, valid/ready on both sides, first-word-fall-through read.
// Optional `level` output port is enabled by defining PARAM_FIFO_LEVEL_EN.
module param_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       almost_full,
  output logic                       almost_empty
`ifdef PARAM_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  if (WIDTH < 1) begin : g_chk_width
    $error("param_sync_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $error("param_sync_fifo: DEPTH must be >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_chk_af
    $error("param_sync_fifo: AF_LEVEL must be in [1, DEPTH]");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL >= DEPTH)) begin : g_chk_ae
    $error("param_sync_fifo: AE_LEVEL must be in [0, DEPTH-1]");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_wr_ptr_next;
  logic [PW-1:0]    w_rd_ptr_next;
  logic             w_push;
  logic             w_pop;

  // Handshake outputs decode registered state only; rst_n gating forces the reset view.
  assign wr_ready     = rst_n & (r_count != FULL_CNT);
  assign rd_valid     = rst_n & (r_count != '0);
  assign almost_full  = rst_n & (r_count >= AF_CNT);
  assign almost_empty = ~rst_n | (r_count <= AE_CNT);
  assign rd_data      = rd_valid ? r_mem[r_rd_ptr] : '0;

`ifdef PARAM_FIFO_LEVEL_EN
  assign level = rst_n ? r_count : '0;
`endif

  assign w_push = wr_valid & wr_ready;
  assign w_pop  = rd_valid & rd_ready;

  // Compare-and-wrap keeps non-power-of-two depths inside [0, DEPTH-1].
  assign w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + ONE_PTR;
  assign w_rd_ptr_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + ONE_PTR;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_next;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a DEPTH=4/WIDTH=8 instance and a DEPTH=5/WIDTH=16 instance.
// Define PARAM_FIFO_LEVEL_EN identically for bench and RTL to exercise the level port.
`timescale 1ns/1ps
module tb_param_sync_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance A: WIDTH 8, DEPTH 4, AF 3, AE 1
  logic        a_wv, a_wr, a_rv, a_rr, a_af, a_ae;
  logic [7:0]  a_wd, a_rd;
  // instance B: WIDTH 16, DEPTH 5, AF 4, AE 1
  logic        b_wv, b_wr, b_rv, b_rr, b_af, b_ae;
  logic [15:0] b_wd, b_rd;
`ifdef PARAM_FIFO_LEVEL_EN
  logic [2:0]  a_lvl, b_lvl;
`endif

  int n_pass  = 0;
  int n_total = 0;

  param_sync_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_fifo_a (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(a_wv), .wr_ready(a_wr), .wr_data(a_wd),
    .rd_valid(a_rv), .rd_ready(a_rr), .rd_data(a_rd),
    .almost_full(a_af), .almost_empty(a_ae)
`ifdef PARAM_FIFO_LEVEL_EN
    , .level(a_lvl)
`endif
  );

  param_sync_fifo #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_fifo_b (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(b_wv), .wr_ready(b_wr), .wr_data(b_wd),
    .rd_valid(b_rv), .rd_ready(b_rr), .rd_data(b_rd),
    .almost_full(b_af), .almost_empty(b_ae)
`ifdef PARAM_FIFO_LEVEL_EN
    , .level(b_lvl)
`endif
  );

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    a_wv = 1'b1; a_wd = d; a_rr = 1'b0;
    step();
    a_wv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_total++;
    if (a_wr !== 1'b0) begin $display("FAIL reset_wr_ready got=%b exp=0", a_wr); end else n_pass++;
    n_total++;
    if (a_rv !== 1'b0) begin $display("FAIL reset_rd_valid got=%b exp=0", a_rv); end else n_pass++;
    n_total++;
    if (a_ae !== 1'b1) begin $display("FAIL reset_almost_empty got=%b exp=1", a_ae); end else n_pass++;
    n_total++;
    if (a_af !== 1'b0) begin $display("FAIL reset_almost_full got=%b exp=0", a_af); end else n_pass++;
    n_total++;
    if (a_rd !== 8'h00) begin $display("FAIL reset_rd_data got=%h exp=00", a_rd); end else n_pass++;
`ifdef PARAM_FIFO_LEVEL_EN
    n_total++;
    if (a_lvl !== 3'd0) begin $display("FAIL reset_level got=%0d exp=0", a_lvl); end else n_pass++;
`endif
    rst_n = 1'b1;
    step();
    n_total++;
    if (a_wr !== 1'b1) begin $display("FAIL release_wr_ready got=%b exp=1", a_wr); end else n_pass++;
    n_total++;
    if (b_wr !== 1'b1) begin $display("FAIL release_b_wr_ready got=%b exp=1", b_wr); end else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int k = 0; k < 4; k++) begin
      push_a(vals[k]);
      n_total++;
      if (a_wr !== (k < 3)) begin $display("FAIL fill_wr_ready[%0d] got=%b exp=%b", k, a_wr, (k < 3)); end else n_pass++;
      n_total++;
      if (a_af !== (k >= 2)) begin $display("FAIL fill_almost_full[%0d] got=%b exp=%b", k, a_af, (k >= 2)); end else n_pass++;
      n_total++;
      if (a_ae !== (k == 0)) begin $display("FAIL fill_almost_empty[%0d] got=%b exp=%b", k, a_ae, (k == 0)); end else n_pass++;
      n_total++;
      if (a_rd !== 8'hA1) begin $display("FAIL fill_head[%0d] got=%h exp=a1", k, a_rd); end else n_pass++;
`ifdef PARAM_FIFO_LEVEL_EN
      n_total++;
      if (a_lvl !== 3'(k + 1)) begin $display("FAIL fill_level[%0d] got=%0d exp=%0d", k, a_lvl, k + 1); end else n_pass++;
`endif
      $display("push a %h wr_ready=%b af=%b", vals[k], a_wr, a_af);
    end
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (a_rv !== 1'b1 || a_rd !== vals[k]) begin
        $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", k, a_rv, a_rd, vals[k]);
      end else n_pass++;
      a_rr = 1'b1;
      step();
      a_rr = 1'b0;
      $display("pop a %h", vals[k]);
    end
    n_total++;
    if (a_rv !== 1'b0) begin $display("FAIL drain_rd_valid got=%b exp=0", a_rv); end else n_pass++;
    n_total++;
    if (a_rd !== 8'h00) begin $display("FAIL drain_rd_data got=%h exp=00", a_rd); end else n_pass++;
    n_total++;
    if (a_ae !== 1'b1 || a_wr !== 1'b1) begin $display("FAIL drain_flags got=ae%b/wr%b exp=1/1", a_ae, a_wr); end else n_pass++;
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp_q [4];
    push_a(8'hB1); push_a(8'hB2); push_a(8'hB3); push_a(8'hB4);
    a_wv = 1'b1; a_wd = 8'hC5; a_rr = 1'b1;
    n_total++;
    if (a_wr !== 1'b0 || a_rd !== 8'hB1) begin $display("FAIL full_pre got=wr%b/%h exp=0/b1", a_wr, a_rd); end else n_pass++;
    step();
    a_rr = 1'b0;
    n_total++;
    if (a_wr !== 1'b1 || a_rd !== 8'hB2 || a_af !== 1'b1) begin
      $display("FAIL full_pop_only got=wr%b/%h/af%b exp=1/b2/1", a_wr, a_rd, a_af);
    end else n_pass++;
`ifdef PARAM_FIFO_LEVEL_EN
    n_total++;
    if (a_lvl !== 3'd3) begin $display("FAIL full_pop_level got=%0d exp=3", a_lvl); end else n_pass++;
`endif
    $display("full cycle a: pop b1, write c5 stalled");
    step();
    a_wv = 1'b0;
    n_total++;
    if (a_wr !== 1'b0) begin $display("FAIL retry_accepted got=wr%b exp=0", a_wr); end else n_pass++;
    exp_q = '{8'hB2, 8'hB3, 8'hB4, 8'hC5};
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (a_rv !== 1'b1 || a_rd !== exp_q[k]) begin
        $display("FAIL retry_drain[%0d] got=%b/%h exp=1/%h", k, a_rv, a_rd, exp_q[k]);
      end else n_pass++;
      a_rr = 1'b1;
      step();
      a_rr = 1'b0;
      $display("pop a %h", exp_q[k]);
    end
    n_total++;
    if (a_rv !== 1'b0) begin $display("FAIL retry_empty got=%b exp=0", a_rv); end else n_pass++;
  endtask

  task automatic test_empty_push_pop();
    a_wv = 1'b1; a_wd = 8'hD7; a_rr = 1'b1;
    n_total++;
    if (a_rv !== 1'b0 || a_rd !== 8'h00) begin $display("FAIL empty_same_cycle got=%b/%h exp=0/00", a_rv, a_rd); end else n_pass++;
    step();
    a_wv = 1'b0;
    n_total++;
    if (a_rv !== 1'b1 || a_rd !== 8'hD7) begin $display("FAIL empty_next_cycle got=%b/%h exp=1/d7", a_rv, a_rd); end else n_pass++;
    step();
    a_rr = 1'b0;
    n_total++;
    if (a_rv !== 1'b0) begin $display("FAIL empty_after_pop got=%b exp=0", a_rv); end else n_pass++;
    $display("empty push/pop a d7");
  endtask

  task automatic test_reset_flush();
    push_a(8'hE1); push_a(8'hE2); push_a(8'hE3);
    rst_n = 1'b0;
    step();
    n_total++;
    if (a_rv !== 1'b0 || a_wr !== 1'b0 || a_ae !== 1'b1) begin
      $display("FAIL flush_during got=rv%b/wr%b/ae%b exp=0/0/1", a_rv, a_wr, a_ae);
    end else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++;
    if (a_rv !== 1'b0 || a_rd !== 8'h00 || a_wr !== 1'b1 || a_af !== 1'b0) begin
      $display("FAIL flush_after got=rv%b/%h/wr%b/af%b exp=0/00/1/0", a_rv, a_rd, a_wr, a_af);
    end else n_pass++;
`ifdef PARAM_FIFO_LEVEL_EN
    n_total++;
    if (a_lvl !== 3'd0) begin $display("FAIL flush_level got=%0d exp=0", a_lvl); end else n_pass++;
`endif
    push_a(8'hF1);
    n_total++;
    if (a_rv !== 1'b1 || a_rd !== 8'hF1) begin $display("FAIL flush_new_head got=%b/%h exp=1/f1", a_rv, a_rd); end else n_pass++;
    a_rr = 1'b1;
    step();
    a_rr = 1'b0;
    n_total++;
    if (a_rv !== 1'b0) begin $display("FAIL flush_no_old_data got=%b/%h exp=0/00", a_rv, a_rd); end else n_pass++;
    $display("reset flush a done");
  endtask

  task automatic test_wrap_depth5();
    bit wv_tab [24];
    bit rr_tab [24];
    logic [15:0] q [$];
    logic [15:0] next_d;
    int cnt;
    bit do_push, do_pop;
    wv_tab = '{1,1,1,1,1,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,1,1,0,0};
    rr_tab = '{0,0,0,0,0,0,1,1,1,1,1,0,0,1,1,1,1,1,1,1,1,1,1,0};
    cnt = 0;
    next_d = 16'h1000;
    for (int i = 0; i < 24; i++) begin
      b_wv = wv_tab[i]; b_rr = rr_tab[i]; b_wd = next_d;
      #1;
      n_total++;
      if (b_wr !== (cnt != 5) || b_rv !== (cnt != 0)) begin
        $display("FAIL wrap_handshake[%0d] got=wr%b/rv%b exp=%b/%b", i, b_wr, b_rv, (cnt != 5), (cnt != 0));
      end else n_pass++;
      n_total++;
      if (b_af !== (cnt >= 4) || b_ae !== (cnt <= 1)) begin
        $display("FAIL wrap_flags[%0d] got=af%b/ae%b exp=%b/%b", i, b_af, b_ae, (cnt >= 4), (cnt <= 1));
      end else n_pass++;
`ifdef PARAM_FIFO_LEVEL_EN
      n_total++;
      if (b_lvl !== 3'(cnt) || b_lvl > 3'd5) begin $display("FAIL wrap_level[%0d] got=%0d exp=%0d", i, b_lvl, cnt); end else n_pass++;
`endif
      do_push = wv_tab[i] && (cnt != 5);
      do_pop  = rr_tab[i] && (cnt != 0);
      if (do_pop) begin
        n_total++;
        if (b_rd !== q[0]) begin $display("FAIL wrap_data[%0d] got=%h exp=%h", i, b_rd, q[0]); end else n_pass++;
      end
      $display("cycle %0d b push=%0b pop=%0b cnt=%0d rd=%h", i, do_push, do_pop, cnt, b_rd);
      step();
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(next_d);
        next_d = next_d + 16'h0001;
      end
      cnt = cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    end
    b_wv = 1'b0; b_rr = 1'b0;
    n_total++;
    if (b_rv !== 1'b0 || b_rd !== 16'h0000) begin $display("FAIL wrap_final got=%b/%h exp=0/0000", b_rv, b_rd); end else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    a_wv = 1'b0; a_wd = '0; a_rr = 1'b0;
    b_wv = 1'b0; b_wd = '0; b_rr = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_pop_push();
    test_empty_push_pop();
    test_reset_flush();
    @(negedge clk);
    test_wrap_depth5();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
